// File: rtl/cache_tag_array.sv
// Set-associative tag store with per-set round-robin replacement, INIT/FLUSH sweeps and registered lookup results.
// Optional per-entry even parity is enabled by defining CACHE_TAG_PARITY_EN.
module cache_tag_array #(
    parameter int INDEX_W = 9,
    parameter int TAG_W   = 18,
    parameter int WAYS    = 2,
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int SETS   = 2 ** INDEX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [INDEX_W-1:0] req_index,
    input  logic [TAG_W-1:0]   req_tag,
    input  logic [WAY_W-1:0]   req_way,
    input  logic               req_dirty,
    input  logic               flush_req,
    output logic               busy,
    output logic               flush_done,
    output logic               rsp_valid,
    output logic               rsp_hit,
    output logic [WAY_W-1:0]   rsp_way,
    output logic               rsp_dirty,
    output logic [WAY_W-1:0]   rsp_victim_way,
    output logic [TAG_W-1:0]   rsp_victim_tag,
    output logic               rsp_victim_valid,
    output logic               rsp_victim_dirty,
    output logic               parity_err
);

    typedef enum logic [1:0] {INIT, IDLE, FLUSH} state_e;

    state_e             state_q, state_d;
    logic [INDEX_W-1:0] sweepIdx_q, sweepIdx_d;
    logic               sweepEn, sweepLast;
    logic               accept, lookupAcc, writeAcc;
    logic [WAY_W-1:0]   wrWay;
    logic [WAY_W-1:0]   rrRd;

    logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
    logic [WAYS-1:0]    valid_q [SETS];
    logic [WAYS-1:0]    dirty_q [SETS];
`ifdef CACHE_TAG_PARITY_EN
    logic [WAYS-1:0]    par_q   [SETS];
`endif

    assign sweepEn   = (state_q != IDLE);
    assign sweepLast = (sweepIdx_q == {INDEX_W{1'b1}});
    assign req_ready = (state_q == IDLE);
    assign busy      = sweepEn;
    assign flush_done = (state_q == FLUSH) && sweepLast;
    assign accept    = req_valid && req_ready && rst_n;
    assign lookupAcc = accept && !req_we;
    assign writeAcc  = accept && req_we;
    assign wrWay     = (WAYS == 1) ? '0 : req_way;

    always_comb begin
        state_d    = state_q;
        sweepIdx_d = sweepIdx_q;
        case (state_q)
            INIT, FLUSH: begin
                sweepIdx_d = sweepIdx_q + 1'b1;
                if (sweepLast) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                // A request presented in the same cycle wins over the flush
                if (flush_req && !req_valid) begin
                    state_d    = FLUSH;
                    sweepIdx_d = '0;
                end
            end
            default: begin
                state_d    = INIT;
                sweepIdx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= INIT;
            sweepIdx_q <= '0;
        end else begin
            state_q    <= state_d;
            sweepIdx_q <= sweepIdx_d;
        end
    end

    // Sweeps zero the whole entry (tag included) so victims never report stale tags
    always_ff @(posedge clk) begin
        if (sweepEn) begin
            for (int w = 0; w < WAYS; w++) begin
                tag_q[sweepIdx_q][w] <= '0;
            end
            valid_q[sweepIdx_q] <= '0;
            dirty_q[sweepIdx_q] <= '0;
`ifdef CACHE_TAG_PARITY_EN
            par_q[sweepIdx_q]   <= '0;
`endif
        end else if (writeAcc) begin
            tag_q[req_index][wrWay]   <= req_tag;
            valid_q[req_index][wrWay] <= 1'b1;
            dirty_q[req_index][wrWay] <= req_dirty;
`ifdef CACHE_TAG_PARITY_EN
            par_q[req_index][wrWay]   <= ^{req_tag, 1'b1, req_dirty};
`endif
        end
    end

    generate
        if (WAYS > 1) begin : g_rr
            logic [WAY_W-1:0] rr_q [SETS];

            always_ff @(posedge clk) begin
                if (sweepEn) begin
                    rr_q[sweepIdx_q] <= '0;
                end else if (writeAcc && (wrWay == rr_q[req_index])) begin
                    rr_q[req_index] <= rr_q[req_index] + 1'b1;
                end
            end

            assign rrRd = rr_q[req_index];
        end else begin : g_no_rr
            assign rrRd = '0;
        end
    endgenerate

    logic [TAG_W-1:0] rdTag [WAYS];
    logic [WAYS-1:0]  rdValid, rdDirty, perr, wayOk;
    logic             hit;
    logic [WAY_W-1:0] hitWay, victimWay;

    // Descending scan so the lowest qualifying way is the one left standing
    always_comb begin
        rdValid = valid_q[req_index];
        rdDirty = dirty_q[req_index];
        perr    = '0;
        for (int w = 0; w < WAYS; w++) begin
            rdTag[w] = tag_q[req_index][w];
        end
`ifdef CACHE_TAG_PARITY_EN
        for (int w = 0; w < WAYS; w++) begin
            perr[w] = par_q[req_index][w] ^ (^{rdTag[w], rdValid[w], rdDirty[w]});
        end
`endif
        wayOk     = rdValid & ~perr;
        hit       = 1'b0;
        hitWay    = '0;
        victimWay = rrRd;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (wayOk[w] && (rdTag[w] == req_tag)) begin
                hit    = 1'b1;
                hitWay = WAY_W'(w);
            end
            if (!wayOk[w]) begin
                victimWay = WAY_W'(w);
            end
        end
    end

    logic             rspValid_q, rspHit_q, rspDirty_q;
    logic [WAY_W-1:0] rspWay_q, rspVicWay_q;
    logic [TAG_W-1:0] rspVicTag_q;
    logic             rspVicValid_q, rspVicDirty_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rspValid_q    <= 1'b0;
            rspHit_q      <= 1'b0;
            rspWay_q      <= '0;
            rspDirty_q    <= 1'b0;
            rspVicWay_q   <= '0;
            rspVicTag_q   <= '0;
            rspVicValid_q <= 1'b0;
            rspVicDirty_q <= 1'b0;
        end else begin
            rspValid_q <= lookupAcc;
            if (lookupAcc) begin
                rspHit_q      <= hit;
                rspWay_q      <= hitWay;
                rspDirty_q    <= hit && rdDirty[hitWay];
                rspVicWay_q   <= victimWay;
                rspVicTag_q   <= rdTag[victimWay];
                rspVicValid_q <= rdValid[victimWay];
                rspVicDirty_q <= rdDirty[victimWay];
            end
        end
    end

`ifdef CACHE_TAG_PARITY_EN
    logic parErr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parErr_q <= 1'b0;
        end else begin
            parErr_q <= lookupAcc && (|perr);
        end
    end

    assign parity_err = parErr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rsp_valid        = rspValid_q;
    assign rsp_hit          = rspHit_q;
    assign rsp_way          = rspWay_q;
    assign rsp_dirty        = rspDirty_q;
    assign rsp_victim_way   = rspVicWay_q;
    assign rsp_victim_tag   = rspVicTag_q;
    assign rsp_victim_valid = rspVicValid_q;
    assign rsp_victim_dirty = rspVicDirty_q;

endmodule

// File: tb/tb_cache_tag_array.sv
// Randomized bench for cache_tag_array against an array-based reference model of the tag store.
module tb_cache_tag_array;

    localparam int SETS = 512;
    localparam int WAYS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_dirty, flush_req;
    logic [8:0]  req_index;
    logic [17:0] req_tag;
    logic [0:0]  req_way;
    logic        busy, flush_done, rsp_valid, rsp_hit, rsp_dirty;
    logic [0:0]  rsp_way, rsp_victim_way;
    logic [17:0] rsp_victim_tag;
    logic        rsp_victim_valid, rsp_victim_dirty, parity_err;

    int testsRun  = 0;
    int failCount = 0;

    int unsigned mTag   [SETS][WAYS];
    bit          mValid [SETS][WAYS];
    bit          mDirty [SETS][WAYS];
    int          mRr    [SETS];

    cache_tag_array dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_index(req_index), .req_tag(req_tag), .req_way(req_way),
        .req_dirty(req_dirty), .flush_req(flush_req),
        .busy(busy), .flush_done(flush_done),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
        .rsp_dirty(rsp_dirty), .rsp_victim_way(rsp_victim_way),
        .rsp_victim_tag(rsp_victim_tag), .rsp_victim_valid(rsp_victim_valid),
        .rsp_victim_dirty(rsp_victim_dirty), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit v, input bit we, input int idx, input int unsigned tag,
                                 input int way, input bit dirty, input bit flush);
        req_valid = v;
        req_we    = we;
        req_index = 9'(idx);
        req_tag   = 18'(tag);
        req_way   = 1'(way);
        req_dirty = dirty;
        flush_req = flush;
    endtask

    task automatic modelClear();
        for (int s = 0; s < SETS; s++) begin
            mRr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                mTag[s][w] = 0; mValid[s][w] = 0; mDirty[s][w] = 0;
            end
        end
    endtask

    task automatic runOp(input bit we, input int idx, input int unsigned tag, input int way, input bit dirty);
        int eHit, eWay, eDirty, vWay;
        eHit = 0; eWay = 0; eDirty = 0; vWay = -1;
        for (int w = 0; w < WAYS; w++) begin
            if (eHit == 0 && mValid[idx][w] && mTag[idx][w] == tag) begin
                eHit = 1; eWay = w; eDirty = int'(mDirty[idx][w]);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!mValid[idx][w]) vWay = w;
        end
        if (vWay < 0) vWay = mRr[idx];
        applyStimulus(1, we, idx, tag, way, dirty, 0);
        tick();
        checkOutput("rsp_valid", rsp_valid, 32'(!we));
        checkOutput("parity_err", parity_err, 0);
        if (!we) begin
            checkOutput("rsp_hit", rsp_hit, eHit);
            checkOutput("rsp_way", rsp_way, eWay);
            checkOutput("rsp_dirty", rsp_dirty, eDirty);
            checkOutput("victim_way", rsp_victim_way, vWay);
            checkOutput("victim_tag", rsp_victim_tag, mTag[idx][vWay]);
            checkOutput("victim_valid", rsp_victim_valid, 32'(mValid[idx][vWay]));
            checkOutput("victim_dirty", rsp_victim_dirty, 32'(mDirty[idx][vWay]));
        end else begin
            mTag[idx][way] = tag; mValid[idx][way] = 1; mDirty[idx][way] = dirty;
            if (way == mRr[idx]) mRr[idx] = (mRr[idx] + 1) % WAYS;
        end
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("idle_rsp_valid", rsp_valid, 0);
    endtask

    // Counts busy cycles from the current sample, recording flush_done pulses
    task automatic measureSweep(input string name, input int expDone);
        int n, fdCnt, fdAt;
        n = 0; fdCnt = 0; fdAt = -1;
        while (busy && n < 2000) begin
            checkOutput({name, "_ready_low"}, req_ready, 0);
            if (flush_done) begin fdCnt++; fdAt = n; end
            n++;
            tick();
        end
        checkOutput({name, "_busy_cycles"}, n, SETS);
        checkOutput({name, "_ready_after"}, req_ready, 1);
        checkOutput({name, "_done_count"}, fdCnt, expDone);
        if (expDone == 1) checkOutput({name, "_done_last"}, fdAt, SETS - 1);
    endtask

    int unsigned tagPool [4] = '{32'h2A5A3, 32'h3, 32'h11111, 32'h3FFFF};
    int          idxPool [6] = '{0, 1, 2, 3, 510, 511};

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        modelClear();
        repeat (3) tick();
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_ready", req_ready, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_flush_done", flush_done, 0);
        checkOutput("rst_parity_err", parity_err, 0);
        checkOutput("rst_victim_tag", rsp_victim_tag, 0);
        rst_n = 1'b1;
        measureSweep("init", 0);

        runOp(0, $urandom_range(0, SETS - 1), $urandom_range(0, 32'h3FFFF), 0, 0);

        runOp(1, 5, 32'h2A5A3, 1, 1);
        runOp(0, 5, 32'h2A5A3, 0, 0);

        runOp(1, 7, 32'h1234, 0, 0);
        runOp(1, 7, 32'h5678, 1, 1);
        runOp(0, 7, 32'h3, 0, 0);
        checkOutput("fill_victim_tag", rsp_victim_tag, 32'h1234);
        idle();

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) idle();
            runOp(1'($urandom_range(0, 1)), idxPool[$urandom_range(0, 5)],
                  tagPool[$urandom_range(0, 3)], $urandom_range(0, 1), 1'($urandom_range(0, 1)));
        end

        applyStimulus(1, 0, 5, 32'h2A5A3, 0, 0, 1);
        tick();
        checkOutput("flush_blocked_rsp", rsp_valid, 1);
        checkOutput("flush_blocked_busy", busy, 0);

        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        measureSweep("flush", 1);
        modelClear();
        runOp(0, 5, 32'h2A5A3, 0, 0);
        runOp(0, 7, 32'h1234, 0, 0);

        runOp(1, 3, 32'h11111, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (200) tick();
        checkOutput("midflush_busy", busy, 1);
        checkOutput("midflush_done", flush_done, 0);
        rst_n = 1'b0;
        tick();
        checkOutput("midflush_rst_rsp", rsp_valid, 0);
        rst_n = 1'b1;
        measureSweep("reinit", 0);
        modelClear();
        runOp(0, 3, 32'h11111, 0, 0);

`ifdef CACHE_TAG_PARITY_EN
        runOp(1, 300, 32'h155AA, 0, 0);
        idle();
        dut.tag_q[300][0] = dut.tag_q[300][0] ^ 18'h200;
        applyStimulus(1, 0, 300, 32'h155AA, 0, 0, 0);
        tick();
        checkOutput("par_rsp_valid", rsp_valid, 1);
        checkOutput("par_hit", rsp_hit, 0);
        checkOutput("par_err", parity_err, 1);
        checkOutput("par_victim_way", rsp_victim_way, 0);
        idle();
        checkOutput("par_err_clear", parity_err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
